// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared types and constants for the pipelined adder/subtractor.
//   op_t    : operation select carried on in_op
//   flags_t : NZCV flag bundle produced by the final stage
//   SAT_MAX / SAT_MIN : signed saturation limits for a w-bit result, returned
//                       right-aligned in a SAT_W-bit vector (callers slice
//                       the low w bits). Widths up to SAT_W are supported.
// Optional feature macro used by the consumers of this package: ADDSUB_SAT_EN.
// -----------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,  // A - B
    OP_RSUB = 2'b10,  // B - A
    OP_RSVD = 2'b11   // reserved, executes as ADD
  } op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Widest result the saturation helpers can describe.
  localparam int SAT_W = 1024;

  // Largest signed w-bit value: 0 followed by w-1 ones.
  function automatic logic [SAT_W-1:0] SAT_MAX(input int w);
    logic [SAT_W-1:0] ones;
    ones = {SAT_W{1'b1}};
    return ones >> (SAT_W - w + 1);
  endfunction

  // Smallest signed w-bit value: 1 followed by w-1 zeros.
  function automatic logic [SAT_W-1:0] SAT_MIN(input int w);
    logic [SAT_W-1:0] one;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    return one << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
// Purely combinational W-bit adder slice with carry in and carry out. One
// instance per pipeline stage; the carry out is registered by the caller.
// Ports:
//   a, b  in  W   chunk operands (already conditioned for SUB/RSUB)
//   cin   in  1   carry from the previous chunk (or the operation's cin)
//   sum   out W   chunk sum
//   cout  out 1   carry out of the chunk
// -----------------------------------------------------------------------------
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] total_s;

  // W+1-bit addition so the top bit is the chunk carry out.
  always_comb begin
    total_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    sum     = total_s[W-1:0];
    cout    = total_s[W];
  end

endmodule

// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
// Pipelined WIDTH-bit adder/subtractor. The carry chain is split into STAGES
// chunks of CHUNK = WIDTH/STAGES bits; stage k adds chunk k and registers the
// partial result, the chunk carry and the untouched operands (skew registers)
// for the next stage. The last stage also produces NZCV flags. Latency is
// STAGES cycles, throughput one beat per cycle, with valid/ready backpressure:
// when the output holds a result nobody takes, the whole pipeline freezes.
//
// Parameters:
//   WIDTH   operand/result width, must be a multiple of STAGES
//   STAGES  number of pipeline stages (1..WIDTH)
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      beat accepted this cycle (combinational)
//   in_a/in_b  in   WIDTH  operands
//   in_op      in   op_t   ADD / SUB (A-B) / RSUB (B-A) / reserved (ADD)
//   in_sat     in   1      saturate on signed overflow (ADDSUB_SAT_EN only)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts the result
//   out_s      out  WIDTH  result
//   out_n/z/c/v out 1      negative, zero, raw carry-out, signed overflow
// Optional feature: define ADDSUB_SAT_EN to add in_sat and signed saturation;
// otherwise results wrap modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef ADDSUB_SAT_EN
  input  logic             in_sat,
`endif
  input  op_t              in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_n,
  output logic             out_z,
  output logic             out_c,
  output logic             out_v
);

  localparam int CHUNK = WIDTH / STAGES;

`ifdef ADDSUB_SAT_EN
  localparam logic [SAT_W-1:0] SAT_HI_FULL = SAT_MAX(WIDTH);
  localparam logic [SAT_W-1:0] SAT_LO_FULL = SAT_MIN(WIDTH);
  localparam logic [WIDTH-1:0] SAT_HI_C    = SAT_HI_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_LO_C    = SAT_LO_FULL[WIDTH-1:0];
`endif

  // Handshake control
  logic             stall_s;
  logic             adv_s;

  // Conditioned operands for the beat at the input
  logic [WIDTH-1:0] cond_x_s;
  logic [WIDTH-1:0] cond_y_s;
  logic             cond_c_s;

  // Per-stage registers: stage k's output, consumed by stage k+1.
  // p_r holds chunks 0..k of the sum; x_r/y_r carry the operands so the
  // higher chunks and the overflow MSBs are still available downstream.
  logic             v_r [STAGES];
  logic [WIDTH-1:0] x_r [STAGES];
  logic [WIDTH-1:0] y_r [STAGES];
  logic [WIDTH-1:0] p_r [STAGES];
  logic             c_r [STAGES];
  flags_t           flags_r;

  // Per-stage inputs (either the conditioned beat or the previous stage)
  logic             st_v_s [STAGES];
  logic [WIDTH-1:0] st_x_s [STAGES];
  logic [WIDTH-1:0] st_y_s [STAGES];
  logic [WIDTH-1:0] st_p_s [STAGES];
  logic             st_c_s [STAGES];

`ifdef ADDSUB_SAT_EN
  logic             sat_r   [STAGES];
  logic             st_sat_s[STAGES];
`endif

  // A result sitting at the output that is not taken freezes everything.
  assign stall_s  = v_r[STAGES-1] & ~out_ready;
  assign adv_s    = ~stall_s;
  assign in_ready = adv_s;

  // Operand conditioning: subtraction is x + ~y + 1 on the chosen operand.
  always_comb begin
    cond_x_s = in_a;
    cond_y_s = in_b;
    cond_c_s = 1'b0;
    case (in_op)
      OP_SUB: begin
        cond_x_s = in_a;
        cond_y_s = ~in_b;
        cond_c_s = 1'b1;
      end
      OP_RSUB: begin
        cond_x_s = ~in_a;
        cond_y_s = in_b;
        cond_c_s = 1'b1;
      end
      default: begin
        cond_x_s = in_a;
        cond_y_s = in_b;
        cond_c_s = 1'b0;
      end
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] sum_s;
    logic             cout_s;
    logic [WIDTH-1:0] nxt_p_s;
    logic [WIDTH-1:0] res_s;

    if (k == 0) begin : g_head
      // in_valid is only sampled when adv_s, so it directly is "accepted".
      assign st_v_s[k] = in_valid;
      assign st_x_s[k] = cond_x_s;
      assign st_y_s[k] = cond_y_s;
      assign st_p_s[k] = {WIDTH{1'b0}};
      assign st_c_s[k] = cond_c_s;
`ifdef ADDSUB_SAT_EN
      assign st_sat_s[k] = in_sat;
`endif
    end else begin : g_body
      assign st_v_s[k] = v_r[k-1];
      assign st_x_s[k] = x_r[k-1];
      assign st_y_s[k] = y_r[k-1];
      assign st_p_s[k] = p_r[k-1];
      assign st_c_s[k] = c_r[k-1];
`ifdef ADDSUB_SAT_EN
      assign st_sat_s[k] = sat_r[k-1];
`endif
    end

    addsub_chunk #(
      .W(CHUNK)
    ) u_chunk (
      .a   (st_x_s[k][k*CHUNK +: CHUNK]),
      .b   (st_y_s[k][k*CHUNK +: CHUNK]),
      .cin (st_c_s[k]),
      .sum (sum_s),
      .cout(cout_s)
    );

    // Merge this stage's chunk into the partial sum.
    always_comb begin
      nxt_p_s = st_p_s[k];
      nxt_p_s[k*CHUNK +: CHUNK] = sum_s;
    end

    if (k == STAGES - 1) begin : g_tail
      logic   ovf_s;
      flags_t flags_s;

      // Final result, optional saturation and NZCV from the completed sum.
      always_comb begin
        ovf_s = (st_x_s[k][WIDTH-1] == st_y_s[k][WIDTH-1]) &
                (nxt_p_s[WIDTH-1] != st_x_s[k][WIDTH-1]);
`ifdef ADDSUB_SAT_EN
        if (st_sat_s[k] && ovf_s) begin
          res_s = st_x_s[k][WIDTH-1] ? SAT_LO_C : SAT_HI_C;
        end else begin
          res_s = nxt_p_s;
        end
`else
        res_s = nxt_p_s;
`endif
        flags_s.n = res_s[WIDTH-1];
        flags_s.z = (res_s == {WIDTH{1'b0}});
        flags_s.c = cout_s;
        flags_s.v = ovf_s;
      end

      // Flag register travels with the final-stage payload.
      always_ff @(posedge clk) begin
        if (rst) begin
          flags_r <= '{n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};
        end else if (adv_s && st_v_s[k]) begin
          flags_r <= flags_s;
        end
      end
    end else begin : g_mid
      assign res_s = nxt_p_s;
    end

    // Stage register: valid shifts on every advance, payload only under a beat.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r[k] <= 1'b0;
        x_r[k] <= {WIDTH{1'b0}};
        y_r[k] <= {WIDTH{1'b0}};
        p_r[k] <= {WIDTH{1'b0}};
        c_r[k] <= 1'b0;
      end else if (adv_s) begin
        v_r[k] <= st_v_s[k];
        if (st_v_s[k]) begin
          x_r[k] <= st_x_s[k];
          y_r[k] <= st_y_s[k];
          p_r[k] <= res_s;
          c_r[k] <= cout_s;
        end
      end
    end

`ifdef ADDSUB_SAT_EN
    // Saturation request rides along with its beat.
    always_ff @(posedge clk) begin
      if (rst) begin
        sat_r[k] <= 1'b0;
      end else if (adv_s && st_v_s[k]) begin
        sat_r[k] <= st_sat_s[k];
      end
    end
`endif
  end

  assign out_valid = v_r[STAGES-1];
  assign out_s     = p_r[STAGES-1];
  assign out_n     = flags_r.n;
  assign out_z     = flags_r.z;
  assign out_c     = flags_r.c;
  assign out_v     = flags_r.v;

endmodule

// File: tb/tb_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_addsub_pipe
// Directed bench for addsub_pipe (WIDTH=64, STAGES=4). Expected values are
// hand-computed constants and a hand-written cycle timeline for the stall run.
// Inputs are driven 1 time unit after the rising edge, outputs checked 1 unit
// later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_addsub_pipe;
  import addsub_pkg::*;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  op_t              in_op;
`ifdef ADDSUB_SAT_EN
  logic             in_sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_n, out_z, out_c, out_v;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  addsub_pipe #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
`ifdef ADDSUB_SAT_EN
    .in_sat   (in_sat),
`endif
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s    (out_s),
    .out_n    (out_n),
    .out_z    (out_z),
    .out_c    (out_c),
    .out_v    (out_v)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: checks in_ready, exact latency, result, flags, and
  // that the following cycle is a bubble. Flags are {n,z,c,v}.
  task automatic single(input string tag, input op_t op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_s,
                        input logic [3:0] exp_f);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    #1;
    chkb({tag, "/in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      #1;
      chkb($sformatf("%s/early_valid%0d", tag, i), out_valid, 1'b0);
      tick();
    end
    #1;
    chkb({tag, "/out_valid"}, out_valid, 1'b1);
    chk({tag, "/out_s"}, out_s, exp_s);
    chk({tag, "/nzcv"}, 64'({out_n, out_z, out_c, out_v}), 64'(exp_f));
    tick();
    #1;
    chkb({tag, "/bubble"}, out_valid, 1'b0);
  endtask

  // Expected output beat per cycle of the stall run (-1 = no result).
  int exp_idx [15] = '{-1, -1, -1, -1, 0, 1, 1, 1, 1, 2, 3, 4, 5, 6, 7};

  initial begin
    int  nb;
    logic exp_rdy;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 64'd0;
    in_b      = 64'd0;
    in_op     = OP_ADD;
    out_ready = 1'b1;
`ifdef ADDSUB_SAT_EN
    in_sat    = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    #1;
    chkb("reset/out_valid", out_valid, 1'b0);
    chkb("reset/in_ready", in_ready, 1'b1);
    chk("reset/out_s", out_s, 64'd0);
    chk("reset/nzcv", 64'({out_n, out_z, out_c, out_v}), 64'd0);

    single("add_1_2", OP_ADD, 64'd1, 64'd2, 64'd3, 4'b0000);
    single("sub_5_7", OP_SUB, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
    single("rsub_5_7", OP_RSUB, 64'd5, 64'd7, 64'd2, 4'b0010);
    single("add_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
           64'h8000_0000_0000_0000, 4'b1001);
`ifdef ADDSUB_SAT_EN
    in_sat = 1'b1;
    single("add_ovf_sat", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
           64'h7FFF_FFFF_FFFF_FFFF, 4'b0001);
    single("sub_ovf_sat", OP_SUB, 64'h8000_0000_0000_0000, 64'd1,
           64'h8000_0000_0000_0000, 4'b1011);
    in_sat = 1'b0;
`endif
    single("add_ripple", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110);
    single("sub_equal", OP_SUB, 64'd5, 64'd5, 64'd0, 4'b0110);
    single("sub_ovf", OP_SUB, 64'h8000_0000_0000_0000, 64'd1,
           64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);

    // Eight back-to-back beats, consumer stalls in cycles 5..7.
    nb = 0;
    for (int c = 0; c < 15; c++) begin
      in_valid  = (nb < 8);
      in_op     = OP_ADD;
      in_a      = 64'h0000_0000_FFFF_FFF0 + 64'(nb);
      in_b      = 64'd16;
      out_ready = !(c >= 5 && c <= 7);
      exp_rdy   = !(c >= 5 && c <= 7);
      #1;
      chkb($sformatf("stream_c%0d/in_ready", c), in_ready, exp_rdy);
      chkb($sformatf("stream_c%0d/out_valid", c), out_valid, exp_idx[c] >= 0);
      if (exp_idx[c] >= 0) begin
        chk($sformatf("stream_c%0d/out_s", c), out_s,
            64'h0000_0001_0000_0000 + 64'(exp_idx[c]));
      end
      if (in_valid && exp_rdy) nb++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chkb("stream/drained", out_valid, 1'b0);

    // Three beats in flight, then reset: none may come out.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = OP_ADD;
      in_a     = 64'(i + 10);
      in_b     = 64'd1;
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chkb("midrst/out_valid", out_valid, 1'b0);
    chkb("midrst/in_ready", in_ready, 1'b1);
    chk("midrst/out_s", out_s, 64'd0);
    chk("midrst/nzcv", 64'({out_n, out_z, out_c, out_v}), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      chkb($sformatf("midrst/stale%0d", i), out_valid, 1'b0);
    end

    single("rsvd_3_4", OP_RSVD, 64'd3, 64'd4, 64'd7, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
